// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, constants and key decode for the keypad security controller
package keypad_pkg;

    localparam logic [15:0] PASSCODE        = 16'h1865;
    localparam int          GRACE_CYCLES    = 256;
    localparam int          DEBOUNCE_CYCLES = 2;
    localparam int          TIMER_W         = $clog2(GRACE_CYCLES + 1);

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        BREACH   = 2'd2,
        ALERT    = 2'd3
    } state_e;

    localparam logic [3:0] COL_0 = 4'b1000;
    localparam logic [3:0] COL_1 = 4'b0100;
    localparam logic [3:0] COL_2 = 4'b0010;
    localparam logic [3:0] COL_3 = 4'b0001;

    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

    // Row/column are one-hot with bit 3 = top row / leftmost column.
    function automatic logic [3:0] decode_key(input logic [3:0] row, input logic [3:0] col);
        logic [1:0] r;
        logic [1:0] c;
        logic [3:0] code;
        case (row)
            4'b0100: r = 2'd1;
            4'b0010: r = 2'd2;
            4'b0001: r = 2'd3;
            default: r = 2'd0;
        endcase
        case (col)
            COL_1:   c = 2'd1;
            COL_2:   c = 2'd2;
            COL_3:   c = 2'd3;
            default: c = 2'd0;
        endcase
        case ({r, c})
            4'h0: code = 4'd1;
            4'h1: code = 4'd2;
            4'h2: code = 4'd3;
            4'h3: code = KEY_A;
            4'h4: code = 4'd4;
            4'h5: code = 4'd5;
            4'h6: code = 4'd6;
            4'h7: code = KEY_B;
            4'h8: code = 4'd7;
            4'h9: code = 4'd8;
            4'hA: code = 4'd9;
            4'hB: code = KEY_C;
            4'hC: code = KEY_STAR;
            4'hD: code = 4'd0;
            4'hE: code = KEY_HASH;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - column scan, freeze, decode; debounce when KEYPAD_DEBOUNCE_EN is defined
module keypad_scanner
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic       key_valid_o,
    output logic [3:0] key_code_o
);

    logic [3:0] col_q, col_d;
    logic       released_q, released_d;
    logic       key_valid_q, key_valid_d;
    logic [3:0] key_code_q, key_code_d;
    logic       accept;
    logic       row_idle;

    assign row_idle = (row_i == 4'b0000);

`ifdef KEYPAD_DEBOUNCE_EN
    localparam int RUN_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_TARGET = RUN_W'(DEBOUNCE_CYCLES);

    logic [3:0]       last_row_q;
    logic [RUN_W-1:0] run_q, run_d;

    // Run length of identical nonzero samples; col is frozen for the whole run.
    always_comb begin
        run_d = run_q;
        if (row_idle) begin
            run_d = '0;
        end else if (row_i != last_row_q) begin
            run_d = RUN_W'(1);
        end else if (run_q != RUN_TARGET) begin
            run_d = run_q + RUN_W'(1);
        end
    end

    assign accept = released_q && !row_idle && (run_d == RUN_TARGET);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_row_q <= 4'b0000;
            run_q      <= '0;
        end else begin
            last_row_q <= row_i;
            run_q      <= run_d;
        end
    end
`else
    assign accept = released_q && !row_idle;
`endif

    always_comb begin
        col_d       = row_idle ? {col_q[0], col_q[3:1]} : col_q;
        released_d  = released_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        if (row_idle) begin
            released_d = 1'b1;
        end else if (accept) begin
            // A multi-row press still consumes the detector so nothing fires until release.
            released_d = 1'b0;
            if (is_one_hot(row_i)) begin
                key_valid_d = 1'b1;
                key_code_d  = decode_key(row_i, col_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= COL_0;
            released_q  <= 1'b1;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
        end else begin
            col_q       <= col_d;
            released_q  <= released_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
        end
    end

    assign col_o       = col_q;
    assign key_valid_o = key_valid_q;
    assign key_code_o  = key_code_q;

endmodule

// File: rtl/keypad_1.sv
// rtl/keypad_1.sv - keypad security controller top: code entry, comparator, grace timer, arm/alert FSM
module keypad_1
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    input  logic       is_breach,
    output logic [3:0] col,
    output logic       is_enabled,
    output logic       led,
    output logic       alert_authorities
);

    logic               key_valid;
    logic [3:0]         key_code;
    logic [15:0]        buf_q, buf_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [15:0]        shifted;
    logic               code_ok, code_bad;
    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;

    keypad_scanner u_scanner (
        .clk         (clk),
        .rst_n       (rst),
        .row_i       (row),
        .col_o       (col),
        .key_valid_o (key_valid),
        .key_code_o  (key_code)
    );

    // The 4th digit is compared straight from the shifted value and never stored.
    always_comb begin
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        code_ok  = 1'b0;
        code_bad = 1'b0;
        shifted  = {buf_q[11:0], key_code};
        if (key_valid) begin
            if (is_digit(key_code)) begin
                if (cnt_q == 3'd3) begin
                    code_ok  = (shifted == PASSCODE);
                    code_bad = (shifted != PASSCODE);
                    buf_d    = 16'd0;
                    cnt_d    = 3'd0;
                end else begin
                    buf_d = shifted;
                    cnt_d = cnt_q + 3'd1;
                end
            end else if (key_code == KEY_STAR) begin
                buf_d = 16'd0;
                cnt_d = 3'd0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            DISARMED: begin
                if (code_ok) state_d = ARMED;
            end
            ARMED: begin
                if (code_ok) begin
                    state_d = DISARMED;
                end else if (is_breach) begin
                    state_d = BREACH;
                    timer_d = TIMER_W'(GRACE_CYCLES);
                end
            end
            BREACH: begin
                // A correct code beats an expiring timer on the same cycle.
                if (code_ok) begin
                    state_d = DISARMED;
                end else if (code_bad || (timer_q == '0)) begin
                    state_d = ALERT;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            ALERT: begin
                if (code_ok) state_d = DISARMED;
            end
            default: state_d = DISARMED;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q   <= 16'd0;
            cnt_q   <= 3'd0;
            state_q <= DISARMED;
            timer_q <= '0;
        end else begin
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    assign is_enabled        = (state_q != DISARMED);
    assign led               = (state_q == BREACH) || (state_q == ALERT);
    assign alert_authorities = (state_q == ALERT);

endmodule

// File: tb/tb_keypad_1.sv
// tb/tb_keypad_1.sv - self-checking bench for keypad_1 against a behavioural model (KEYPAD_DEBOUNCE_EN aware)
module tb_keypad_1;
    import keypad_pkg::*;

`ifdef KEYPAD_DEBOUNCE_EN
    localparam int DB = DEBOUNCE_CYCLES;
`else
    localparam int DB = 1;
`endif
    localparam int CODE_VALUE = 1865;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row = 4'b0000;
    logic       is_breach = 1'b0;
    logic [3:0] col;
    logic       is_enabled, led, alert_authorities;

    keypad_1 dut (
        .clk               (clk),
        .rst               (rst),
        .row               (row),
        .is_breach         (is_breach),
        .col               (col),
        .is_enabled        (is_enabled),
        .led               (led),
        .alert_authorities (alert_authorities)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: keypad layout, digit list, named state, absolute alert deadline.
    int key_tbl [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};
    int         st_m = 0;        // 0 disarmed, 1 armed, 2 breach, 3 alert
    int         digits_m[$];
    int         pend_m = 0;      // 0 none, 1 correct code, 2 wrong code
    longint     cyc_m = 0;
    longint     deadline_m = 0;
    bit         released_m = 1'b1;
    logic [3:0] prev_row_m = 4'b0000;
    int         run_m = 0;
    int         col_idx_m = 0;

    function automatic logic [3:0] col_of(input int idx);
        logic [3:0] v;
        v = 4'b1000;
        return v >> idx;
    endfunction

    function automatic int row_index(input logic [3:0] r);
        int idx = 0;
        for (int i = 0; i < 4; i++) if (r[3-i]) idx = i;
        return idx;
    endfunction

    task automatic model_key(input int code);
        int value;
        if (code <= 9) begin
            digits_m.push_back(code);
            if (digits_m.size() == 4) begin
                value = digits_m[0] * 1000 + digits_m[1] * 100 + digits_m[2] * 10 + digits_m[3];
                pend_m = (value == CODE_VALUE) ? 1 : 2;
                digits_m.delete();
            end
        end else if (code == 14) begin
            digits_m.delete();
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_m = 0; digits_m.delete(); pend_m = 0; cyc_m = 0; deadline_m = 0;
            released_m = 1'b1; prev_row_m = 4'b0000; run_m = 0; col_idx_m = 0;
        end else begin
            cyc_m++;
            case (st_m)
                0: if (pend_m == 1) st_m = 1;
                1: if (pend_m == 1) st_m = 0;
                   else if (is_breach) begin st_m = 2; deadline_m = cyc_m + GRACE_CYCLES + 1; end
                2: if (pend_m == 1) st_m = 0;
                   else if (pend_m == 2 || cyc_m >= deadline_m) st_m = 3;
                default: if (pend_m == 1) st_m = 0;
            endcase
            pend_m = 0;
            if (row == 4'b0000) begin
                released_m = 1'b1;
                run_m = 0;
                col_idx_m = (col_idx_m + 1) % 4;
            end else begin
                run_m = (row == prev_row_m) ? run_m + 1 : 1;
                if (released_m && run_m >= DB) begin
                    released_m = 1'b0;
                    if ($countones(row) == 1) model_key(key_tbl[row_index(row)][col_idx_m]);
                end
            end
            prev_row_m = row;
        end
    end

    bit mon_en = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            check("col", col, col_of(col_idx_m));
            check("is_enabled", is_enabled, st_m != 0);
            check("led", led, st_m >= 2);
            check("alert", alert_authorities, st_m == 3);
        end
    end

    int breach_mode = 0;   // 0 hold, 1 random pulses, 2 toggle every cycle

    task automatic tick();
        @(negedge clk);
        if (breach_mode == 1) is_breach = ($urandom_range(0, 39) == 0);
        else if (breach_mode == 2) is_breach = ~is_breach;
    endtask

    task automatic press(input int code, input int hold);
        int r = 0;
        int c = 0;
        int n = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (key_tbl[i][j] == code) begin r = i; c = j; end
        while (col_idx_m != c && n < 16) begin tick(); n++; end
        check("col_reach", n < 16, 1'b1);
        row = col_of(r);
        repeat (hold) tick();
        row = 4'b0000;
        tick();
    endtask

    task automatic enter(input int d0, input int d1, input int d2, input int d3);
        press(d0, DB + 1); press(d1, DB + 1); press(d2, DB + 1); press(d3, DB + 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_col", col, 4'b1000);
        check("rst_en", is_enabled, 1'b0);
        check("rst_led", led, 1'b0);
        check("rst_alert", alert_authorities, 1'b0);
        #2 rst = 1'b1;
    endtask

    initial begin
        int k;
        int sel;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_col", col, 4'b1000);
        check("rst_en", is_enabled, 1'b0);
        check("rst_led", led, 1'b0);
        check("rst_alert", alert_authorities, 1'b0);
        #2 rst = 1'b1;
        mon_en = 1'b1;

        enter(1, 8, 6, 5);
        check("arm_en", is_enabled, 1'b1);
        check("arm_led", led, 1'b0);

        is_breach = 1'b1;
        press(1, DB + 1);
        is_breach = 1'b0;
        check("breach_led", led, 1'b1);
        press(8, DB + 1); press(6, DB + 1); press(5, DB + 1);
        check("disarm_en", is_enabled, 1'b0);
        check("disarm_led", led, 1'b0);

        breach_mode = 2;
        enter(0, 0, 0, 0);
        breach_mode = 0; is_breach = 1'b0;
        check("wrong_disarmed_en", is_enabled, 1'b0);
        check("wrong_disarmed_alert", alert_authorities, 1'b0);

        enter(1, 8, 6, 5);
        is_breach = 1'b1; tick(); is_breach = 1'b0;
        enter(0, 0, 0, 0);
        check("wrong_code_alert", alert_authorities, 1'b1);
        enter(1, 8, 6, 5);
        check("alert_cleared", alert_authorities, 1'b0);
        check("alert_cleared_en", is_enabled, 1'b0);

        enter(1, 8, 6, 5);
        is_breach = 1'b1;
        @(posedge clk);
        k = 0;
        @(negedge clk);
        is_breach = 1'b0;
        while (!alert_authorities && k < 1000) begin @(posedge clk); k++; @(negedge clk); end
        check("grace_latency", k, GRACE_CYCLES + 1);
        enter(1, 8, 6, 5);

        press(1, DB + 1); press(8, DB + 1); press(14, DB + 1);
        enter(1, 8, 6, 5);
        check("star_arm", is_enabled, 1'b1);
        enter(1, 8, 6, 5);
        while (col_idx_m != 1) tick();
        row = 4'b1100;
        repeat (3) begin tick(); check("dual_row_freeze", col, 4'b0100); end
        row = 4'b0000; tick();
        enter(1, 8, 6, 5);
        check("dual_row_ignored", is_enabled, 1'b1);
        enter(1, 8, 6, 5);

        press(1, DB + 1); press(8, DB + 1);
        do_reset();
        press(6, DB + 1); press(5, DB + 1);
        check("reset_mid_entry", is_enabled, 1'b0);
        enter(1, 8, 6, 5);
        is_breach = 1'b1; tick(); is_breach = 1'b0;
        do_reset();

        breach_mode = 1;
        for (int s = 0; s < 40; s++) begin
            sel = $urandom_range(0, 3);
            if (sel == 3) begin
                press($urandom_range(0, 15), DB + $urandom_range(0, 2));
                press($urandom_range(0, 15), DB + $urandom_range(0, 2));
            end
            if (sel == 2) begin
                for (int d = 0; d < 4; d++) press($urandom_range(0, 9), DB + $urandom_range(0, 2));
            end else begin
                press(1, DB + $urandom_range(0, 2)); press(8, DB + $urandom_range(0, 2));
                press(6, DB + $urandom_range(0, 2)); press(5, DB + $urandom_range(0, 2));
            end
            if (s % 10 == 9) repeat (300) tick();
        end
        breach_mode = 0; is_breach = 1'b0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule
